// File: rtl/ram_host_arbiter.sv
// ram_host_arbiter
// Merges the instruction-fetch port and the LSU data port onto a single
// 1-cycle-latency RAM request port. Round-robin arbitration with a same-cycle
// grant; each response is routed back to the host that issued the request.
// Accesses outside [BaseAddr, BaseAddr + 4*Depth) are answered locally with
// an error and never reach the RAM.
module ram_host_arbiter #(
  parameter int unsigned Depth    = 16384,
  parameter logic [31:0] BaseAddr = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // instruction fetch port
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  // LSU data port
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  // RAM request port
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic        ram_rvalid_i,
  input  logic [31:0] ram_rdata_i
);

  localparam logic [31:0] DepthW = 32'(Depth);

  typedef enum logic {
    HostInstr = 1'b0,
    HostData  = 1'b1
  } host_e;

  // Outstanding response: one per grant, answered exactly one cycle later.
  typedef struct packed {
    logic  valid;
    host_e owner;
    logic  err;
  } rsp_t;

  host_e       rr_last_q, rr_last_d;
  rsp_t        rsp_q, rsp_d;
  logic        gnt_instr, gnt_data, grant;
  host_e       gnt_host;
  logic [31:0] req_addr;
  logic [31:0] addr_off;
  logic        in_range;
  logic        rsp_fire;
  logic [31:0] rsp_data;

  // Round-robin arbitration; grants are suppressed while reset is asserted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    gnt_data  = 1'b0;
    gnt_instr = 1'b0;
    if (rst_ni) begin
      if (data_req_i && (!instr_req_i || rr_last_q == HostInstr)) begin
        gnt_data = 1'b1;
      end else if (instr_req_i) begin
        gnt_instr = 1'b1;
      end
    end
  end

  assign grant    = gnt_instr | gnt_data;
  assign gnt_host = gnt_data ? HostData : HostInstr;
  assign req_addr = gnt_data ? data_addr_i : instr_addr_i;

  // Unsigned subtract: addresses below BaseAddr wrap high and fall out of range.
  assign addr_off = req_addr - BaseAddr;
  assign in_range = (addr_off >> 2) < DepthW;

  assign instr_gnt_o = gnt_instr;
  assign data_gnt_o  = gnt_data;

  // Forward the granted in-range request to the RAM; otherwise drive an idle port.
  always_comb begin
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    ram_addr_o  = 32'h0;
    ram_wdata_o = 32'h0;
    if (grant && in_range) begin
      ram_req_o  = 1'b1;
      ram_addr_o = {req_addr[31:2], 2'b00};
      if (gnt_data) begin
        ram_we_o    = data_we_i;
        ram_be_o    = data_be_i;
        ram_wdata_o = data_wdata_i;
      end else begin
        ram_be_o = 4'hF;
      end
    end
  end

  // Next-state: remember the last granted host and who owns next cycle's response.
  always_comb begin
    rr_last_d = rr_last_q;
    rsp_d     = '0;
    if (grant) begin
      rr_last_d   = gnt_host;
      rsp_d.valid = 1'b1;
      rsp_d.owner = gnt_host;
      rsp_d.err   = ~in_range;
    end
  end

  // State registers; an asserted reset drops any response still in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_ni) begin
      rr_last_q <= HostInstr;
      rsp_q     <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      rsp_q     <= rsp_d;
    end
  end

  // Errors respond without waiting on the RAM; stray RAM responses are ignored.
  assign rsp_fire = rsp_q.valid & (rsp_q.err | ram_rvalid_i);
  assign rsp_data = rsp_q.err ? 32'h0 : ram_rdata_i;

  // Route the response to its owner; the other host sees all zeros.
  always_comb begin
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = 32'h0;
    instr_err_o    = 1'b0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = 32'h0;
    data_err_o     = 1'b0;
    if (rsp_q.valid) begin
      if (rsp_q.owner == HostInstr) begin
        instr_rvalid_o = rsp_fire;
        instr_rdata_o  = rsp_data;
        instr_err_o    = rsp_q.err;
      end else begin
        data_rvalid_o = rsp_fire;
        data_rdata_o  = rsp_data;
        data_err_o    = rsp_q.err;
      end
    end
  end

endmodule

// File: tb/tb_ram_host_arbiter.sv
// tb_ram_host_arbiter
// Drives both hosts, plays the RAM with a sparse memory, and compares every
// cycle against a transaction-level model of arbitration, range check and
// response routing. A second instance with a non-zero base checks address wrap.
module tb_ram_host_arbiter;

  localparam logic [31:0] BASE_A  = 32'h0000_0000;
  localparam longint      DEPTH_A = 16384;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  // DUT A signals
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = 32'h0;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i = 1'b0, data_we_i = 1'b0;
  logic [3:0]  data_be_i = 4'h0;
  logic [31:0] data_addr_i = 32'h0, data_wdata_i = 32'h0;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        ram_req_o, ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic        ram_rvalid_i = 1'b0;
  logic [31:0] ram_rdata_i = 32'h0;

  // DUT B signals (BaseAddr = 0x0010_0000)
  logic        b_instr_req_i = 1'b0;
  logic [31:0] b_instr_addr_i = 32'h0;
  logic        b_instr_gnt_o, b_instr_rvalid_o, b_instr_err_o;
  logic [31:0] b_instr_rdata_o;
  logic        b_data_gnt_o, b_data_rvalid_o, b_data_err_o;
  logic [31:0] b_data_rdata_o;
  logic        b_ram_req_o, b_ram_we_o;
  logic [3:0]  b_ram_be_o;
  logic [31:0] b_ram_addr_o, b_ram_wdata_o;
  logic        b_zero = 1'b0;
  logic [3:0]  b_zero4 = 4'h0;
  logic [31:0] b_zero32 = 32'h0;
  logic [31:0] b_ram_rdata_i = 32'hDEAD_BEEF;

  ram_host_arbiter #(.Depth(16384), .BaseAddr(BASE_A)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i)
  );

  ram_host_arbiter #(.Depth(16384), .BaseAddr(32'h0010_0000)) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(b_instr_req_i), .instr_addr_i(b_instr_addr_i), .instr_gnt_o(b_instr_gnt_o),
    .instr_rvalid_o(b_instr_rvalid_o), .instr_rdata_o(b_instr_rdata_o), .instr_err_o(b_instr_err_o),
    .data_req_i(b_zero), .data_we_i(b_zero), .data_be_i(b_zero4),
    .data_addr_i(b_zero32), .data_wdata_i(b_zero32), .data_gnt_o(b_data_gnt_o),
    .data_rvalid_o(b_data_rvalid_o), .data_rdata_o(b_data_rdata_o), .data_err_o(b_data_err_o),
    .ram_req_o(b_ram_req_o), .ram_we_o(b_ram_we_o), .ram_be_o(b_ram_be_o), .ram_addr_o(b_ram_addr_o),
    .ram_wdata_o(b_ram_wdata_o), .ram_rvalid_i(b_zero), .ram_rdata_i(b_ram_rdata_i)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit rst_drv  = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          v;
    bit          owner;  // 0 = instr, 1 = data
    bit          err;
    bit          we;
    logic [31:0] rdata;
  } exp_rsp_t;

  bit       m_last = 1'b0;   // last granted host, 0 = instr
  exp_rsp_t m_pend;

  logic [31:0] mem_m [bit [29:0]];  // model's view of RAM contents
  logic [31:0] mem_s [bit [29:0]];  // RAM stub contents, written from the DUT's RAM port

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {16'hC0DE, a[15:2], 2'b00};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd_m(input logic [31:0] a);
    if (mem_m.exists(a[31:2])) return mem_m[a[31:2]];
    return init_word(a);
  endfunction

  function automatic logic [31:0] rd_s(input logic [31:0] a);
    if (mem_s.exists(a[31:2])) return mem_s[a[31:2]];
    return init_word(a);
  endfunction

  function automatic bit in_win(input logic [31:0] a, input logic [31:0] base, input longint depth);
    longint x = a;
    longint b = base;
    return (x >= b) && (x < b + 4 * depth);
  endfunction

  // values sampled at the compare point, for the hand-computed checks
  logic        act_gi, act_gd, act_rreq, act_rwe, act_irv, act_drv, act_ierr, act_derr;
  logic [3:0]  act_rbe;
  logic [31:0] act_raddr, act_irdata, act_drdata;
  logic        act_b_gnt, act_b_req, act_b_rv, act_b_err;
  logic [31:0] act_b_addr, act_b_rdata;

  // RAM stub capture
  bit          s_req, s_we;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wdata;

  task automatic compare_cycle();
    bit gi, gd, ok, err;
    logic [31:0] a;
    exp_rsp_t nxt;
    act_gi = instr_gnt_o;  act_gd = data_gnt_o;  act_rreq = ram_req_o;  act_rwe = ram_we_o;
    act_rbe = ram_be_o;    act_raddr = ram_addr_o;
    act_irv = instr_rvalid_o; act_ierr = instr_err_o; act_irdata = instr_rdata_o;
    act_drv = data_rvalid_o;  act_derr = data_err_o;  act_drdata = data_rdata_o;
    act_b_gnt = b_instr_gnt_o; act_b_req = b_ram_req_o; act_b_addr = b_ram_addr_o;
    act_b_rv = b_instr_rvalid_o; act_b_err = b_instr_err_o; act_b_rdata = b_instr_rdata_o;

    if (!rst_ni) m_pend.v = 1'b0;
    gi = 1'b0;
    gd = 1'b0;
    if (rst_ni) begin
      if (instr_req_i && data_req_i) begin
        if (m_last) gi = 1'b1; else gd = 1'b1;
      end else begin
        gi = instr_req_i;
        gd = data_req_i;
      end
    end
    check("instr_gnt", instr_gnt_o, gi);
    check("data_gnt", data_gnt_o, gd);

    a   = gd ? data_addr_i : instr_addr_i;
    err = !in_win(a, BASE_A, DEPTH_A);
    ok  = (gi || gd) && !err;
    check("ram_req", ram_req_o, ok);
    if (ok) begin
      check("ram_addr", ram_addr_o, a & 32'hFFFF_FFFC);
      check("ram_we", ram_we_o, gd ? data_we_i : 1'b0);
      check("ram_be", ram_be_o, gd ? data_be_i : 4'hF);
      check("ram_wdata", ram_wdata_o, gd ? data_wdata_i : 32'h0);
    end else if (!(gi || gd)) begin
      check("ram_idle", {ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o}, 96'h0);
    end

    check("instr_rvalid", instr_rvalid_o, m_pend.v && !m_pend.owner);
    check("data_rvalid", data_rvalid_o, m_pend.v && m_pend.owner);
    if (m_pend.v) begin
      if (!m_pend.owner) begin
        check("instr_err", instr_err_o, m_pend.err);
        if (!m_pend.we) check("instr_rdata", instr_rdata_o, m_pend.err ? 32'h0 : m_pend.rdata);
        check("data_idle", {data_err_o, data_rdata_o}, 96'h0);
      end else begin
        check("data_err", data_err_o, m_pend.err);
        if (!m_pend.we) check("data_rdata", data_rdata_o, m_pend.err ? 32'h0 : m_pend.rdata);
        check("instr_idle", {instr_err_o, instr_rdata_o}, 96'h0);
      end
    end

    nxt = '{v: 1'b0, owner: 1'b0, err: 1'b0, we: 1'b0, rdata: 32'h0};
    if (gi || gd) begin
      m_last    = gd;
      nxt.v     = 1'b1;
      nxt.owner = gd;
      nxt.err   = err;
      nxt.we    = gd && data_we_i;
      if (!err && !nxt.we) nxt.rdata = rd_m(a);
      if (!err && nxt.we) mem_m[a[31:2]] = merge(rd_m(a), data_wdata_i, data_be_i);
    end
    if (!rst_ni) m_last = 1'b0;
    m_pend = nxt;

    s_req = ram_req_o; s_we = ram_we_o; s_be = ram_be_o; s_addr = ram_addr_o; s_wdata = ram_wdata_o;
  endtask

  // RAM stub: answers one cycle after a request, occasionally raises a stray rvalid.
  task automatic stub_update();
    if (s_req) begin
      if (s_we) mem_s[s_addr[31:2]] = merge(rd_s(s_addr), s_wdata, s_be);
      ram_rvalid_i = 1'b1;
      ram_rdata_i  = rd_s(s_addr);
    end else begin
      ram_rvalid_i = ($urandom_range(0, 3) == 0);
      ram_rdata_i  = $urandom;
    end
  endtask

  task automatic cycle(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                       input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dw);
    @(negedge clk_i);
    rst_ni = rst_drv;
    instr_req_i = ir; instr_addr_i = ia;
    data_req_i = dr; data_we_i = dwe; data_be_i = dbe; data_addr_i = da; data_wdata_i = dw;
    #1;
    compare_cycle();
    @(posedge clk_i);
    #1;
    stub_update();
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst_drv = 1'b0;
    idle();
    idle();
    rst_drv = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 16383)) << 2;
      1:       return 32'h0000_FFFC;
      2:       return 32'h0001_0000;
      3:       return 32'h0000_0000;
      4:       return $urandom;
      default: return $urandom & 32'h0000_003F;
    endcase
  endfunction

  initial begin
    m_pend = '{v: 1'b0, owner: 1'b0, err: 1'b0, we: 1'b0, rdata: 32'h0};
    do_reset();

    // Single fetch read
    cycle(1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("t1_gnt", act_gi, 1'b1);
    check("t1_addr", act_raddr, 32'h10);
    check("t1_be", act_rbe, 4'hF);
    idle();
    check("t1_rvalid", act_irv, 1'b1);
    check("t1_rdata", act_irdata, 32'hC0DE_0010);
    check("t1_err", act_ierr, 1'b0);

    // Contention after reset: D, I, D, I
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 32'h0000_0020, 1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0);
      check("t2_gnt_d", act_gd, (k % 2) == 0);
      check("t2_gnt_i", act_gi, (k % 2) == 1);
      if (k > 0) check("t2_rsp_route", {act_irv, act_drv}, (k % 2) == 1 ? 2'b01 : 2'b10);
    end
    idle();
    check("t2_last_rsp", {act_irv, act_drv}, 2'b10);

    // Partial write at the top word, then read back
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h0000_FFFC, 32'h1234_5678);
    check("t3_req", act_rreq, 1'b1);
    check("t3_we", act_rwe, 1'b1);
    check("t3_be", act_rbe, 4'h3);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0000_FFFC, 32'h0);
    check("t3_wrsp", {act_drv, act_derr}, 2'b10);
    idle();
    check("t3_readback", act_drdata, 32'hC0DE_5678);

    // First word past the window
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0);
    check("t4_gnt", act_gd, 1'b1);
    check("t4_noreq", act_rreq, 1'b0);
    idle();
    check("t4_rsp", {act_drv, act_derr}, 2'b11);
    check("t4_rdata", act_drdata, 32'h0);

    // Reset while a response is in flight
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
    check("t6_gnt", act_gd, 1'b1);
    rst_drv = 1'b0;
    idle();
    check("t6_dropped", {act_irv, act_drv}, 2'b00);
    cycle(1'b1, 32'h0000_0004, 1'b1, 1'b0, 4'hF, 32'h0000_0008, 32'h0);
    check("t6_no_gnt_in_rst", {act_gi, act_gd}, 2'b00);
    rst_drv = 1'b1;
    idle();
    check("t6_no_rvalid", {act_irv, act_drv}, 2'b00);
    cycle(1'b1, 32'h0000_0004, 1'b1, 1'b0, 4'hF, 32'h0000_0008, 32'h0);
    check("t6_data_first", {act_gi, act_gd}, 2'b01);
    idle();

    // Non-zero base: wrap below base, window edges
    b_instr_req_i = 1'b1; b_instr_addr_i = 32'h000F_FFFC;
    idle();
    check("t5_gnt", act_b_gnt, 1'b1);
    check("t5_noreq", act_b_req, 1'b0);
    b_instr_addr_i = 32'h0010_0000;
    idle();
    check("t5_err_rsp", {act_b_rv, act_b_err}, 2'b11);
    check("t5_err_rdata", act_b_rdata, 32'h0);
    check("t5_base_req", act_b_req, 1'b1);
    check("t5_base_addr", act_b_addr, 32'h0010_0000);
    b_instr_addr_i = 32'h0011_0000;
    idle();
    check("t5_top_noreq", {act_b_gnt, act_b_req}, 2'b10);
    check("t5_wait_ram", act_b_rv, 1'b0);
    b_instr_req_i = 1'b0;
    idle();
    check("t5_top_err", {act_b_rv, act_b_err}, 2'b11);

    // Randomised traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst_drv = ($urandom_range(0, 399) != 0);
      cycle($urandom_range(0, 9) < 6, rand_addr(), $urandom_range(0, 9) < 6,
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_addr(), $urandom);
    end
    rst_drv = 1'b1;
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
